// File: rtl/rtc_alarm_ctrl.sv
// rtc_alarm_ctrl: time-of-day controller with alarm channels.
//   Keeps HH:MM:SS from a one-cycle 1 Hz strobe and offers three modes (NORMAL, TIMESET,
//   ALARMSET). It has NUM_ALARMS alarm channels with a self-clearing ring output, validated
//   host time loads, and LED display fields. Every input strobe is a single-cycle level.
// Ports:
//   clock, reset_n                     clock and asynchronous active-low reset
//   tick                               1 Hz strobe
//   button{0,1,2}_signal[_long]        short / long button strobes
//   load_valid, load_hr/min/sec        host time load
//   load_error, sync_request           one-cycle status pulses
//   hr_out, min_out, sec_out           current time
//   led_num0, led_num1, led_dot        display fields
//   mode, alarm_sel, alarm_ring        mode, selected alarm, per-channel ring flags
module rtc_alarm_ctrl #(
  parameter int unsigned NUM_ALARMS   = 2,
  parameter int unsigned RING_SECONDS = 30
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  button0_signal,
  input  logic                  button0_signal_long,
  input  logic                  button1_signal,
  input  logic                  button1_signal_long,
  input  logic                  button2_signal,
  input  logic                  button2_signal_long,
  input  logic                  load_valid,
  input  logic [4:0]            load_hr,
  input  logic [5:0]            load_min,
  input  logic [5:0]            load_sec,
  output logic                  load_error,
  output logic                  sync_request,
  output logic [4:0]            hr_out,
  output logic [5:0]            min_out,
  output logic [5:0]            sec_out,
  output logic [5:0]            led_num0,
  output logic [5:0]            led_num1,
  output logic                  led_dot,
  output logic [1:0]            mode,
  output logic [2:0]            alarm_sel,
  output logic [NUM_ALARMS-1:0] alarm_ring
);

  localparam logic [1:0] ModeNormal   = 2'd0;
  localparam logic [1:0] ModeTimeset  = 2'd1;
  localparam logic [1:0] ModeAlarmset = 2'd2;

  logic [4:0]            hr_q, hr_d;
  logic [5:0]            min_q, min_d;
  logic [5:0]            sec_q, sec_d;
  logic [1:0]            mode_q, mode_d;
  logic                  hhmm_q, hhmm_d;   // 1 = HHMM position, 0 = MMSS
  logic                  dir1_q, dir1_d;   // 1 = step down
  logic                  dir2_q, dir2_d;
  logic [2:0]            sel_q, sel_d;
  logic [4:0]            alm_hr_q  [NUM_ALARMS];
  logic [4:0]            alm_hr_d  [NUM_ALARMS];
  logic [5:0]            alm_min_q [NUM_ALARMS];
  logic [5:0]            alm_min_d [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] alm_en_q, alm_en_d;
  logic [NUM_ALARMS-1:0] ring_q, ring_d;
  logic [7:0]            ring_cnt_q, ring_cnt_d;
  logic                  load_error_q, load_error_d;
  logic                  sync_req_q, sync_req_d;

  function automatic logic [5:0] step_field(input logic [5:0] val, input logic down,
                                            input logic [5:0] top);
    if (down) begin
      return (val == 6'd0) ? top : val - 6'd1;
    end
    return (val == top) ? 6'd0 : val + 6'd1;
  endfunction

  function automatic logic [4:0] step_hr(input logic [4:0] val, input logic down);
    if (down) begin
      return (val == 5'd0) ? 5'd23 : val - 5'd1;
    end
    return (val == 5'd23) ? 5'd0 : val + 5'd1;
  endfunction

  // Fields of the currently selected alarm.
  logic [4:0] sel_hr;
  logic [5:0] sel_min;
  logic       sel_en;

  always_comb begin
    sel_hr  = '0;
    sel_min = '0;
    sel_en  = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (sel_q == 3'(i)) begin
        sel_hr  = alm_hr_q[i];
        sel_min = alm_min_q[i];
        sel_en  = alm_en_q[i];
      end
    end
  end

  // Time after one tick, and the alarms that this new time matches.
  logic [4:0]            hr_inc;
  logic [5:0]            min_inc;
  logic [5:0]            sec_inc;
  logic [NUM_ALARMS-1:0] hit;

  always_comb begin
    sec_inc = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
    min_inc = min_q;
    hr_inc  = hr_q;
    if (sec_q == 6'd59) begin
      min_inc = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      if (min_q == 6'd59) begin
        hr_inc = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
      end
    end
    for (int i = 0; i < NUM_ALARMS; i++) begin
      hit[i] = alm_en_q[i] && (sec_inc == 6'd0) && (alm_hr_q[i] == hr_inc) &&
               (alm_min_q[i] == min_inc);
    end
  end

  // One action per cycle, in priority order; lower-priority strobes are dropped.
  always_comb begin
    hr_d         = hr_q;
    min_d        = min_q;
    sec_d        = sec_q;
    mode_d       = mode_q;
    hhmm_d       = hhmm_q;
    dir1_d       = dir1_q;
    dir2_d       = dir2_q;
    sel_d        = sel_q;
    alm_hr_d     = alm_hr_q;
    alm_min_d    = alm_min_q;
    alm_en_d     = alm_en_q;
    ring_d       = ring_q;
    ring_cnt_d   = ring_cnt_q;
    load_error_d = 1'b0;
    sync_req_d   = 1'b0;

    if (load_valid) begin
      if (mode_q == ModeNormal) begin
        if (load_hr <= 5'd23 && load_min <= 6'd59 && load_sec <= 6'd59) begin
          hr_d  = load_hr;
          min_d = load_min;
          sec_d = load_sec;
        end else begin
          load_error_d = 1'b1;
        end
      end
    end else if (button0_signal_long) begin
      case (mode_q)
        ModeNormal: begin
          mode_d     = ModeTimeset;
          ring_d     = '0;
          ring_cnt_d = '0;
        end
        ModeTimeset: mode_d = ModeAlarmset;
        default:     mode_d = ModeNormal;
      endcase
    end else if (button0_signal) begin
      if (mode_q == ModeAlarmset) begin
        sel_d = (sel_q == 3'(NUM_ALARMS - 1)) ? 3'd0 : sel_q + 3'd1;
      end else begin
        hhmm_d = ~hhmm_q;
      end
    end else if (button1_signal_long || button1_signal) begin
      case (mode_q)
        ModeNormal: begin
          ring_d     = '0;
          ring_cnt_d = '0;
        end
        ModeTimeset: begin
          if (hhmm_q) hr_d = step_hr(hr_q, dir1_q);
          else        min_d = step_field(min_q, dir1_q, 6'd59);
          if (button1_signal_long) dir1_d = ~dir1_q;
        end
        default: begin
          for (int i = 0; i < NUM_ALARMS; i++) begin
            if (sel_q == 3'(i)) alm_hr_d[i] = step_hr(alm_hr_q[i], dir1_q);
          end
          if (button1_signal_long) dir1_d = ~dir1_q;
        end
      endcase
    end else if (button2_signal_long) begin
      case (mode_q)
        ModeNormal: begin
          ring_d     = '0;
          ring_cnt_d = '0;
        end
        ModeTimeset: begin
          if (hhmm_q) min_d = step_field(min_q, dir2_q, 6'd59);
          else        sec_d = step_field(sec_q, dir2_q, 6'd59);
          dir2_d = ~dir2_q;
        end
        default: begin
          for (int i = 0; i < NUM_ALARMS; i++) begin
            if (sel_q == 3'(i)) alm_en_d[i] = ~alm_en_q[i];
          end
        end
      endcase
    end else if (button2_signal) begin
      case (mode_q)
        ModeNormal: begin
          if (|ring_q) begin
            ring_d     = '0;
            ring_cnt_d = '0;
          end else begin
            sync_req_d = 1'b1;
          end
        end
        ModeTimeset: begin
          if (hhmm_q) min_d = step_field(min_q, dir2_q, 6'd59);
          else        sec_d = step_field(sec_q, dir2_q, 6'd59);
        end
        default: begin
          for (int i = 0; i < NUM_ALARMS; i++) begin
            if (sel_q == 3'(i)) alm_min_d[i] = step_field(alm_min_q[i], dir2_q, 6'd59);
          end
        end
      endcase
    end else if (tick && mode_q == ModeNormal) begin
      hr_d  = hr_inc;
      min_d = min_inc;
      sec_d = sec_inc;
      if (|hit) begin
        ring_d     = ring_q | hit;
        ring_cnt_d = 8'(RING_SECONDS);
      end else if (ring_cnt_q != 8'd0) begin
        ring_cnt_d = ring_cnt_q - 8'd1;
        if (ring_cnt_q == 8'd1) ring_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hr_q         <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      mode_q       <= ModeNormal;
      hhmm_q       <= 1'b0;
      dir1_q       <= 1'b0;
      dir2_q       <= 1'b0;
      sel_q        <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alm_hr_q[i]  <= '0;
        alm_min_q[i] <= '0;
      end
      alm_en_q     <= '0;
      ring_q       <= '0;
      ring_cnt_q   <= '0;
      load_error_q <= 1'b0;
      sync_req_q   <= 1'b0;
    end else begin
      hr_q         <= hr_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      mode_q       <= mode_d;
      hhmm_q       <= hhmm_d;
      dir1_q       <= dir1_d;
      dir2_q       <= dir2_d;
      sel_q        <= sel_d;
      alm_hr_q     <= alm_hr_d;
      alm_min_q    <= alm_min_d;
      alm_en_q     <= alm_en_d;
      ring_q       <= ring_d;
      ring_cnt_q   <= ring_cnt_d;
      load_error_q <= load_error_d;
      sync_req_q   <= sync_req_d;
    end
  end

  always_comb begin
    if (mode_q == ModeAlarmset) begin
      led_num0 = {1'b0, sel_hr};
      led_num1 = sel_min;
      led_dot  = sel_en;
    end else begin
      if (hhmm_q) begin
        led_num0 = {1'b0, hr_q};
        led_num1 = min_q;
      end else begin
        led_num0 = min_q;
        led_num1 = sec_q;
      end
      led_dot = (mode_q == ModeNormal) ? sec_q[0] : 1'b0;
    end
  end

  assign hr_out       = hr_q;
  assign min_out      = min_q;
  assign sec_out      = sec_q;
  assign mode         = mode_q;
  assign alarm_sel    = sel_q;
  assign alarm_ring   = ring_q;
  assign load_error   = load_error_q;
  assign sync_request = sync_req_q;

endmodule

// File: tb/tb_rtc_alarm_ctrl.sv
// Self-checking bench for rtc_alarm_ctrl: directed scenarios plus randomized strobes, all
// checked every cycle against a seconds-of-day reference model.
module tb_rtc_alarm_ctrl;

  localparam int NA = 2;
  localparam int RS = 30;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          tick;
  logic          button0_signal, button0_signal_long;
  logic          button1_signal, button1_signal_long;
  logic          button2_signal, button2_signal_long;
  logic          load_valid;
  logic [4:0]    load_hr;
  logic [5:0]    load_min, load_sec;
  logic          load_error, sync_request;
  logic [4:0]    hr_out;
  logic [5:0]    min_out, sec_out;
  logic [5:0]    led_num0, led_num1;
  logic          led_dot;
  logic [1:0]    mode;
  logic [2:0]    alarm_sel;
  logic [NA-1:0] alarm_ring;

  rtc_alarm_ctrl #(
    .NUM_ALARMS  (NA),
    .RING_SECONDS(RS)
  ) u_dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .tick               (tick),
    .button0_signal     (button0_signal),
    .button0_signal_long(button0_signal_long),
    .button1_signal     (button1_signal),
    .button1_signal_long(button1_signal_long),
    .button2_signal     (button2_signal),
    .button2_signal_long(button2_signal_long),
    .load_valid         (load_valid),
    .load_hr            (load_hr),
    .load_min           (load_min),
    .load_sec           (load_sec),
    .load_error         (load_error),
    .sync_request       (sync_request),
    .hr_out             (hr_out),
    .min_out            (min_out),
    .sec_out            (sec_out),
    .led_num0           (led_num0),
    .led_num1           (led_num1),
    .led_dot            (led_dot),
    .mode               (mode),
    .alarm_sel          (alarm_sel),
    .alarm_ring         (alarm_ring)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: time as seconds of day, ring as a remaining-seconds count.
  int            m_t, m_mode, m_sel, m_ring_left;
  bit            m_hhmm, m_d1, m_d2, m_lerr, m_sreq;
  int            m_ahr [NA];
  int            m_amin[NA];
  bit            m_aen [NA];
  logic [NA-1:0] m_ring;

  function automatic int wrapstep(input int v, input bit down, input int n);
    return down ? (v + n - 1) % n : (v + 1) % n;
  endfunction

  task automatic model_reset();
    m_t = 0; m_mode = 0; m_sel = 0; m_ring_left = 0;
    m_hhmm = 0; m_d1 = 0; m_d2 = 0; m_lerr = 0; m_sreq = 0;
    m_ring = '0;
    for (int i = 0; i < NA; i++) begin
      m_ahr[i] = 0; m_amin[i] = 0; m_aen[i] = 0;
    end
  endtask

  task automatic clear_ring();
    m_ring = '0;
    m_ring_left = 0;
  endtask

  task automatic model_apply();
    int h, m, s;
    logic [NA-1:0] hits;
    m_lerr = 0;
    m_sreq = 0;
    h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
    if (load_valid) begin
      if (m_mode == 0) begin
        if (load_hr <= 23 && load_min <= 59 && load_sec <= 59)
          m_t = int'(load_hr) * 3600 + int'(load_min) * 60 + int'(load_sec);
        else
          m_lerr = 1;
      end
    end else if (button0_signal_long) begin
      m_mode = (m_mode + 1) % 3;
      if (m_mode == 1) clear_ring();
    end else if (button0_signal) begin
      if (m_mode == 2) m_sel = (m_sel + 1) % NA;
      else m_hhmm = !m_hhmm;
    end else if (button1_signal_long || button1_signal) begin
      if (m_mode == 0) clear_ring();
      else begin
        if (m_mode == 1) begin
          if (m_hhmm) h = wrapstep(h, m_d1, 24);
          else m = wrapstep(m, m_d1, 60);
          m_t = h * 3600 + m * 60 + s;
        end else begin
          m_ahr[m_sel] = wrapstep(m_ahr[m_sel], m_d1, 24);
        end
        if (button1_signal_long) m_d1 = !m_d1;
      end
    end else if (button2_signal_long) begin
      if (m_mode == 0) clear_ring();
      else if (m_mode == 1) begin
        if (m_hhmm) m = wrapstep(m, m_d2, 60);
        else s = wrapstep(s, m_d2, 60);
        m_t = h * 3600 + m * 60 + s;
        m_d2 = !m_d2;
      end else begin
        m_aen[m_sel] = !m_aen[m_sel];
      end
    end else if (button2_signal) begin
      if (m_mode == 0) begin
        if (m_ring != 0) clear_ring();
        else m_sreq = 1;
      end else if (m_mode == 1) begin
        if (m_hhmm) m = wrapstep(m, m_d2, 60);
        else s = wrapstep(s, m_d2, 60);
        m_t = h * 3600 + m * 60 + s;
      end else begin
        m_amin[m_sel] = wrapstep(m_amin[m_sel], m_d2, 60);
      end
    end else if (tick && m_mode == 0) begin
      m_t = (m_t + 1) % 86400;
      hits = '0;
      for (int i = 0; i < NA; i++)
        if (m_aen[i] && m_t == m_ahr[i] * 3600 + m_amin[i] * 60) hits[i] = 1'b1;
      if (hits != 0) begin
        m_ring = m_ring | hits;
        m_ring_left = RS;
      end else if (m_ring_left > 0) begin
        m_ring_left--;
        if (m_ring_left == 0) m_ring = '0;
      end
    end
  endtask

  task automatic check_all();
    int h, m, s, e0, e1, ed;
    h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
    if (m_mode == 2) begin
      e0 = m_ahr[m_sel]; e1 = m_amin[m_sel]; ed = int'(m_aen[m_sel]);
    end else begin
      e0 = m_hhmm ? h : m;
      e1 = m_hhmm ? m : s;
      ed = (m_mode == 0) ? s % 2 : 0;
    end
    check_eq("hr_out", hr_out, h);
    check_eq("min_out", min_out, m);
    check_eq("sec_out", sec_out, s);
    check_eq("mode", mode, m_mode);
    check_eq("alarm_sel", alarm_sel, m_sel);
    check_eq("alarm_ring", alarm_ring, m_ring);
    check_eq("led_num0", led_num0, e0);
    check_eq("led_num1", led_num1, e1);
    check_eq("led_dot", led_dot, ed);
    check_eq("load_error", load_error, m_lerr);
    check_eq("sync_request", sync_request, m_sreq);
  endtask

  task automatic clear_inputs();
    tick = 0; load_valid = 0; load_hr = '0; load_min = '0; load_sec = '0;
    button0_signal = 0; button0_signal_long = 0;
    button1_signal = 0; button1_signal_long = 0;
    button2_signal = 0; button2_signal_long = 0;
  endtask

  // Inputs are set 1 ns after an edge; the model steps on the edge and outputs are checked
  // 1 ns later.
  task automatic cycle();
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_apply();
    #1;
    check_all();
    clear_inputs();
  endtask

  task automatic set_load(input int h, input int m, input int s);
    load_valid = 1;
    load_hr  = 5'(h);
    load_min = 6'(m);
    load_sec = 6'(s);
  endtask

  initial begin
    int tt, k;
    reset_n = 0;
    clear_inputs();
    model_reset();
    #12;
    check_all();
    check_eq("rst_hr", hr_out, 0);
    check_eq("rst_mode", mode, 0);
    check_eq("rst_ring", alarm_ring, 0);
    @(posedge clock); #1;
    reset_n = 1;
    cycle();

    // Midnight rollover.
    set_load(23, 59, 58); cycle();
    button0_signal = 1; cycle();
    tick = 1; cycle();
    check_eq("sec_59", sec_out, 59);
    tick = 1; cycle();
    check_eq("wrap_hr", hr_out, 0);
    check_eq("wrap_led0", led_num0, 0);
    check_eq("wrap_led1", led_num1, 0);

    // Rejected and ignored loads.
    set_load(24, 0, 0); cycle();
    check_eq("lerr_pulse", load_error, 1);
    cycle();
    check_eq("lerr_clear", load_error, 0);
    button0_signal_long = 1; cycle();
    set_load(12, 0, 0); cycle();
    check_eq("ts_load_hr", hr_out, 0);
    check_eq("ts_load_err", load_error, 0);

    // TIMESET minute stepping in MMSS.
    button0_signal = 1; cycle();
    button1_signal = 1; cycle();
    check_eq("ts_min1", min_out, 1);
    tick = 1; cycle();
    button1_signal_long = 1; cycle();
    check_eq("ts_min2", min_out, 2);
    button1_signal = 1; cycle();
    tick = 1; cycle();
    button1_signal = 1; cycle();
    check_eq("ts_min0", min_out, 0);
    button1_signal = 1; cycle();
    check_eq("ts_min59", min_out, 59);
    check_eq("ts_hr", hr_out, 0);
    check_eq("ts_sec", sec_out, 0);

    // ALARMSET: alarm 1 at 07:30, enabled.
    button0_signal_long = 1; cycle();
    button0_signal = 1; cycle();
    button1_signal_long = 1; cycle();
    for (int i = 0; i < 8; i++) begin button1_signal = 1; cycle(); end
    for (int i = 0; i < 30; i++) begin button2_signal = 1; cycle(); end
    button2_signal_long = 1; cycle();
    check_eq("as_dot", led_dot, 1);
    check_eq("as_hr", led_num0, 7);
    check_eq("as_min", led_num1, 30);
    check_eq("as_sel", alarm_sel, 1);

    // Trigger and timeout.
    button0_signal_long = 1; cycle();
    set_load(7, 29, 59); cycle();
    tick = 1; cycle();
    check_eq("ring_on", alarm_ring, 2'b10);
    for (int i = 0; i < 29; i++) begin tick = 1; cycle(); end
    check_eq("ring_held", alarm_ring, 2'b10);
    tick = 1; cycle();
    check_eq("ring_timeout", alarm_ring, 0);

    // Button clears ring without sync; next press syncs.
    set_load(7, 29, 59); cycle();
    tick = 1; cycle();
    button2_signal = 1; cycle();
    check_eq("ring_clr", alarm_ring, 0);
    check_eq("no_sync", sync_request, 0);
    button2_signal = 1; cycle();
    check_eq("sync_pulse", sync_request, 1);
    cycle();
    check_eq("sync_end", sync_request, 0);

    // Reset while ringing.
    set_load(7, 29, 59); cycle();
    tick = 1; cycle();
    check_eq("ring_again", alarm_ring, 2'b10);
    reset_n = 0;
    #2;
    model_reset();
    check_all();
    cycle();
    reset_n = 1;
    cycle();

    // Same-cycle priority: load wins over button0_long and tick.
    set_load(1, 2, 3); button0_signal_long = 1; tick = 1; cycle();
    check_eq("prio_sec", sec_out, 3);
    check_eq("prio_mode", mode, 0);
    button0_signal_long = 1; cycle();
    check_eq("prio_next", mode, 1);
    button0_signal_long = 1; cycle();
    button0_signal_long = 1; cycle();

    // Randomized strobes.
    for (int n = 0; n < 4000; n++) begin
      tick = ($urandom_range(0, 99) < 60);
      button0_signal_long = ($urandom_range(0, 59) == 0);
      button0_signal      = ($urandom_range(0, 24) == 0);
      button1_signal_long = ($urandom_range(0, 29) == 0);
      button1_signal      = ($urandom_range(0, 14) == 0);
      button2_signal_long = ($urandom_range(0, 29) == 0);
      button2_signal      = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 14) == 0) begin
        case ($urandom_range(0, 3))
          0: begin
            load_valid = 1;
            load_hr  = 5'($urandom_range(0, 31));
            load_min = 6'($urandom_range(0, 63));
            load_sec = 6'($urandom_range(0, 63));
          end
          1: begin
            k  = int'($urandom_range(0, NA - 1));
            tt = (m_ahr[k] * 3600 + m_amin[k] * 60 + 86400 - int'($urandom_range(1, 3))) % 86400;
            set_load(tt / 3600, (tt / 60) % 60, tt % 60);
          end
          default: set_load(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                            int'($urandom_range(0, 59)));
        endcase
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
